cla_multicycle_adder: RTL

- Parametrised multi-cycle carry-lookahead adder.
- Adds two WIDTH-bit operands one GROUP-bit slice per clock. Each slice uses a full GROUP-bit generate/propagate lookahead network, and the slice carry-out is registered into the next slice.
- Trades latency for area in the datapath labs. Used where a full-width single-cycle lookahead tree is too large; gives start/busy/done sequencing to the surrounding controller.

---
 rtl/cla_multicycle_adder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/cla_multicycle_adder.sv
// Multi-cycle carry-lookahead adder: one GROUP-bit slice per clock, with the slice
// carry-out registered into the next slice. Start/Busy/Done sequencing.
module cla_multicycle_adder #(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow,
  output logic [1:0]       state_dbg
);

  localparam int N  = WIDTH / GROUP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  // Handshake: Start is accepted on a rising Clk while in IDLE or DONE; Busy is
  // high for exactly N cycles afterwards, then Done pulses for one cycle with
  // Sum/Cout/Overflow valid and held until the next accepted Start.

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    k_q, k_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;
  logic             busy_q, busy_d, done_q, done_d;

  logic [GROUP-1:0] a_slice, b_slice, g, p, slice_sum;
  logic [GROUP:0]   c;
  logic             last_slice;

  // Each carry is a flat sum of products of g/p/cin, not a ripple through c[i].
  function automatic logic [GROUP:0] lookahead(input logic [GROUP-1:0] gi,
                                               input logic [GROUP-1:0] pi,
                                               input logic             cin);
    logic [GROUP:0] cc;
    logic           term;
    cc    = '0;
    cc[0] = cin;
    for (int i = 0; i < GROUP; i++) begin
      term = cin;
      for (int m = 0; m <= i; m++) term = term & pi[m];
      cc[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = gi[j];
        for (int m = j + 1; m <= i; m++) term = term & pi[m];
        cc[i+1] = cc[i+1] | term;
      end
    end
    return cc;
  endfunction

  always_comb begin
    int base;
    base       = int'(k_q) * GROUP;
    a_slice    = a_q[base +: GROUP];
    b_slice    = b_q[base +: GROUP];
    g          = a_slice & b_slice;
    p          = a_slice ^ b_slice;
    c          = lookahead(g, p, carry_q);
    slice_sum  = p ^ c[GROUP-1:0];
    last_slice = (k_q == CW'(N - 1));

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    k_d     = k_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          sum_d   = '0;
          k_d     = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[base +: GROUP] = slice_sum;
        carry_d = c[GROUP];
        k_d     = k_q + CW'(1);
        if (last_slice) begin
          cout_d  = c[GROUP];
          ovf_d   = c[GROUP-1] ^ c[GROUP];
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign Overflow  = ovf_q;
  assign state_dbg = state_q;

endmodule
